// File: rtl/perf_region_pkg.sv
// Shared definitions for the performance-region controller: register map,
// FSM state encoding and the full-width record layout seen on the bus.
package perf_region_pkg;

  localparam logic [2:0] OFF_START    = 3'd0;
  localparam logic [2:0] OFF_STOP     = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_HEAD_CYC = 3'd3;
  localparam logic [2:0] OFF_HEAD_ID  = 3'd4;
  localparam logic [2:0] OFF_POP      = 3'd5;
  localparam logic [2:0] OFF_HEAD_RET = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Head record as presented on the bus, every field zero-extended.
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] cyc;
    logic [31:0] ret;
  } rec_t;

endpackage

// File: rtl/perf_region_if.sv
// Device-bus bundle for the performance-region controller, with the
// requester (master) and responder (slave) views.
interface perf_region_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output rvalid, rdata);
endinterface

// File: rtl/perf_region_fifo.sv
// Record FIFO: synchronous push/pop with exact occupancy; pushes when full
// and pops when empty are ignored.
module perf_region_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [Width-1:0]           din,
  input  logic                       pop,
  output logic [Width-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int AddrW  = $clog2(Depth);
  localparam int CountW = AddrW + 1;

  logic [Width-1:0]  mem [Depth];
  logic [AddrW-1:0]  wptr_reg, rptr_reg;
  logic [CountW-1:0] count_reg;
  logic              do_push, do_pop;

  assign full    = (count_reg == CountW'(Depth));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg] <= din;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + AddrW'(1);
      if (do_pop)  rptr_reg <= rptr_reg + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CountW'(1);
        2'b01:   count_reg <= count_reg - CountW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/perf_region_ctrl.sv
// Region profiler: START/STOP bracket a region, cycle (and optionally retired
// instruction, macro PERF_REGION_INSTRET_EN) counts are queued per region.
module perf_region_ctrl
  import perf_region_pkg::*;
#(
  parameter int FifoDepth = 8,
  parameter int CntWidth  = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        instr_ret_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

`ifdef PERF_REGION_INSTRET_EN
  localparam int RecW = 8 + 2 * CntWidth;
`else
  localparam int RecW = 8 + CntWidth;
`endif
  localparam int CountW = $clog2(FifoDepth) + 1;

  state_t              state_reg, state_next;
  logic [7:0]          id_reg;
  logic [CntWidth-1:0] cyc_reg, cyc_inc;
  logic                clear_cnt, stop_req;
  logic                wr, wr_start, wr_stop, wr_status, wr_pop;
  logic [2:0]          off;
  logic                ovf_reg;
  logic                full, empty;
  logic [CountW-1:0]   occ;
  logic [RecW-1:0]     din, dout;
  rec_t                head;
  logic [31:0]         rd_mux;
  logic                rvalid_reg;
  logic [31:0]         rdata_reg;
  logic                unused_sink;

  assign off       = addr_i[4:2];
  assign wr        = req_i && we_i;
  assign wr_start  = wr && (off == OFF_START);
  assign wr_stop   = wr && (off == OFF_STOP);
  assign wr_status = wr && (off == OFF_STATUS);
  assign wr_pop    = wr && (off == OFF_POP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    clear_cnt  = 1'b0;
    stop_req   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wr_start) begin
          state_next = ST_RUN;
          clear_cnt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (wr_start) begin
          clear_cnt = 1'b1;
        end else if (wr_stop) begin
          stop_req   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The recorded value is one tick ahead so the STOP cycle itself counts.
  assign cyc_inc = (&cyc_reg) ? cyc_reg : cyc_reg + CntWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_reg <= '0;
      id_reg  <= '0;
    end else if (clear_cnt) begin
      cyc_reg <= '0;
      id_reg  <= wdata_i[7:0];
    end else if (state_reg == ST_RUN) begin
      cyc_reg <= cyc_inc;
    end
  end

`ifdef PERF_REGION_INSTRET_EN
  logic [CntWidth-1:0] ret_reg, ret_inc, ret_final;

  assign ret_inc   = (&ret_reg) ? ret_reg : ret_reg + CntWidth'(1);
  assign ret_final = instr_ret_i ? ret_inc : ret_reg;
  assign din       = {id_reg, cyc_inc, ret_final};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                      ret_reg <= '0;
    else if (clear_cnt)                               ret_reg <= '0;
    else if ((state_reg == ST_RUN) && instr_ret_i)    ret_reg <= ret_inc;
  end

  assign unused_sink = ^{be_i, addr_i[31:5], addr_i[1:0], wdata_i[31:8]};
`else
  assign din         = {id_reg, cyc_inc};
  assign unused_sink = ^{be_i, addr_i[31:5], addr_i[1:0], wdata_i[31:8], instr_ret_i};
`endif

  perf_region_fifo #(
    .Width (RecW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (stop_req && !full),
    .din   (din),
    .pop   (wr_pop && !empty),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  ovf_reg <= 1'b0;
    else if (wr_status)           ovf_reg <= 1'b0;
    else if (stop_req && full)    ovf_reg <= 1'b1;
  end

  always_comb begin
    head = '0;
    if (!empty) begin
      head.id  = dout[RecW-1 -: 8];
      head.cyc = 32'(dout[RecW-9 -: CntWidth]);
`ifdef PERF_REGION_INSTRET_EN
      head.ret = 32'(dout[CntWidth-1:0]);
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATUS:   rd_mux = (32'(occ) << 4) | {30'b0, ovf_reg, state_reg == ST_RUN};
      OFF_HEAD_CYC: rd_mux = head.cyc;
      OFF_HEAD_ID:  rd_mux = {24'b0, head.id};
      OFF_HEAD_RET: rd_mux = head.ret;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= req_i;
      rdata_reg  <= (req_i && !we_i) ? rd_mux : '0;
    end
  end

  assign rvalid_o = rvalid_reg;
  assign rdata_o  = rdata_reg;

endmodule

// File: tb/tb_perf_region_ctrl.sv
// Bench for perf_region_ctrl: a 32-bit and an 8-bit counter instance share one
// bus; a queue-based region model predicts every response.
module tb_perf_region_ctrl;

  localparam int DEPTH = 8;

  typedef struct {
    int unsigned      id;
    longint unsigned  cyc;
    longint unsigned  ret;
  } mrec_t;

  logic        clk;
  logic        rst_n;
  logic        iret_s;
  logic        rvalid_b;
  logic [31:0] rdata_b;

  perf_region_if bus ();

  perf_region_ctrl #(.FifoDepth(DEPTH), .CntWidth(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(bus.req), .we_i(bus.we), .be_i(bus.be),
    .addr_i(bus.addr), .wdata_i(bus.wdata), .instr_ret_i(iret_s),
    .rvalid_o(bus.rvalid), .rdata_o(bus.rdata)
  );

  perf_region_ctrl #(.FifoDepth(DEPTH), .CntWidth(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(bus.req), .we_i(bus.we), .be_i(bus.be),
    .addr_i(bus.addr), .wdata_i(bus.wdata), .instr_ret_i(iret_s),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          edge_n = 0;
  bit          m_run = 0;
  bit          m_ovf = 0;
  int          m_start = 0;
  int unsigned m_id = 0;
  longint unsigned m_ret = 0;
  mrec_t       q[$];

  function automatic logic [31:0] sat(longint unsigned v, int w);
    longint unsigned m;
    m = (64'd1 << w) - 1;
    return (v > m) ? m[31:0] : v[31:0];
  endfunction

  function automatic logic [31:0] exp_read(logic [2:0] off, int w);
    logic [4:0] occ;
    occ = 5'(q.size());
    case (off)
      3'd2: return {23'b0, occ, 2'b0, m_ovf, m_run};
      3'd3: return (q.size() > 0) ? sat(q[0].cyc, w) : 32'h0;
      3'd4: return (q.size() > 0) ? q[0].id : 32'h0;
`ifdef PERF_REGION_INSTRET_EN
      3'd6: return (q.size() > 0) ? sat(q[0].ret, w) : 32'h0;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(string tag, logic [32:0] obs, logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, clock, update the model, then check both instances.
  task automatic tick(string tag, bit rq, bit wr, logic [2:0] off, logic [31:0] wd, bit iret);
    logic [32:0] ea, eb;
    logic [26:0] up;
    up        = 27'($urandom);
    bus.req   = rq;
    bus.we    = wr;
    bus.be    = 4'($urandom);
    bus.addr  = {up, off, 2'b00};
    bus.wdata = wd;
    iret_s    = iret;
    ea = {rq, (rq && !wr) ? exp_read(off, 32) : 32'h0};
    eb = {rq, (rq && !wr) ? exp_read(off, 8) : 32'h0};
    @(posedge clk);
    edge_n++;
    if (rq && wr && off == 3'd0) begin
      m_run = 1; m_start = edge_n; m_ret = 0; m_id = wd[7:0];
    end else if (m_run) begin
      if (iret) m_ret++;
      if (rq && wr && off == 3'd1) begin
        m_run = 0;
        if (q.size() < DEPTH) q.push_back('{m_id, longint'(edge_n - m_start), m_ret});
        else m_ovf = 1;
      end
    end
    if (rq && wr && off == 3'd2) m_ovf = 0;
    if (rq && wr && off == 3'd5 && q.size() > 0) void'(q.pop_front());
    #1;
    check({tag, "_a"}, {bus.rvalid, bus.rdata}, ea);
    check({tag, "_b"}, {rvalid_b, rdata_b}, eb);
    $display("txn %s req=%0d we=%0d off=%0d wd=%h -> a=%h b=%h occ=%0d",
             tag, rq, wr, off, wd, bus.rdata, rdata_b, q.size());
    bus.req = 0; bus.we = 0; iret_s = 0;
  endtask

  task automatic idle(int n, bit iret);
    for (int i = 0; i < n; i++) tick("idle", 0, 0, 3'd0, 32'h0, iret);
  endtask

  task automatic do_reset(int n);
    #2 rst_n = 0;
    m_run = 0; m_ovf = 0; q.delete();
    #1;
    check("rst_async_a", {bus.rvalid, bus.rdata}, 33'h0);
    check("rst_async_b", {rvalid_b, rdata_b}, 33'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("rst_hold_a", {bus.rvalid, bus.rdata}, 33'h0);
      check("rst_hold_b", {rvalid_b, rdata_b}, 33'h0);
    end
    rst_n = 1;
    $display("txn reset cycles=%0d", n);
  endtask

  initial begin
    rst_n = 1; iret_s = 0;
    bus.req = 0; bus.we = 0; bus.be = 0; bus.addr = 0; bus.wdata = 0;
    do_reset(3);
    tick("rst_status", 1, 0, 3'd2, 0, 0);
    tick("rst_cyc", 1, 0, 3'd3, 0, 0);

    // Basic 100-cycle region.
    tick("start5a", 1, 1, 3'd0, 32'h5A, 0);
    idle(99, 0);
    tick("stop", 1, 1, 3'd1, 0, 0);
    tick("cyc100", 1, 0, 3'd3, 0, 0);
    tick("id5a", 1, 0, 3'd4, 0, 0);
    tick("status1", 1, 0, 3'd2, 0, 0);
    tick("pop", 1, 1, 3'd5, 0, 0);

    // Restart discards the first region.
    tick("start01", 1, 1, 3'd0, 32'h01, 0);
    idle(49, 0);
    tick("start02", 1, 1, 3'd0, 32'h02, 0);
    idle(19, 0);
    tick("stop", 1, 1, 3'd1, 0, 0);
    tick("status_r", 1, 0, 3'd2, 0, 0);
    tick("cyc20", 1, 0, 3'd3, 0, 0);
    tick("id02", 1, 0, 3'd4, 0, 0);
    tick("pop", 1, 1, 3'd5, 0, 0);

    // 300-cycle region saturates the 8-bit instance; STOP in IDLE is inert.
    tick("start03", 1, 1, 3'd0, 32'h03, 0);
    idle(299, 0);
    tick("stop", 1, 1, 3'd1, 0, 0);
    tick("cyc_sat", 1, 0, 3'd3, 0, 0);
    tick("stop_idle", 1, 1, 3'd1, 0, 0);
    tick("status_idle", 1, 0, 3'd2, 0, 0);
    tick("pop", 1, 1, 3'd5, 0, 0);

    // 37 retired-instruction pulses inside a region.
    tick("start07", 1, 1, 3'd0, 32'h07, 0);
    for (int i = 0; i < 60; i++) tick("iret", 0, 0, 3'd0, 0, i < 37);
    tick("stop", 1, 1, 3'd1, 0, 0);
    tick("ret37", 1, 0, 3'd6, 0, 0);
    tick("pop", 1, 1, 3'd5, 0, 0);

    // Fill past capacity, clear overflow, drain, pop on empty.
    for (int k = 0; k < 9; k++) begin
      tick("fill_start", 1, 1, 3'd0, 32'(8'h10 + k), 0);
      idle(k, 0);
      tick("fill_stop", 1, 1, 3'd1, 0, 0);
    end
    tick("status_full", 1, 0, 3'd2, 0, 0);
    tick("head_id_full", 1, 0, 3'd4, 0, 0);
    tick("ovf_clear", 1, 1, 3'd2, 32'hFFFF_FFFF, 0);
    tick("status_clr", 1, 0, 3'd2, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick("drain_cyc", 1, 0, 3'd3, 0, 0);
      tick("drain_pop", 1, 1, 3'd5, 0, 0);
    end
    tick("status_empty", 1, 0, 3'd2, 0, 0);
    tick("cyc_empty", 1, 0, 3'd3, 0, 0);
    tick("pop_empty", 1, 1, 3'd5, 0, 0);
    tick("status_empty2", 1, 0, 3'd2, 0, 0);
    tick("off7_wr", 1, 1, 3'd7, 32'h1234_5678, 0);
    tick("off7_rd", 1, 0, 3'd7, 0, 0);

    // Reset in the middle of a region, with a response in flight.
    tick("start_rst", 1, 1, 3'd0, 32'h44, 0);
    idle(10, 1);
    tick("status_run", 1, 0, 3'd2, 0, 0);
    do_reset(2);
    tick("status_post_rst", 1, 0, 3'd2, 0, 0);
    tick("cyc_post_rst", 1, 0, 3'd3, 0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      int unsigned op;
      bit ir;
      op = $urandom_range(0, 11);
      ir = 1'($urandom);
      case (op)
        0:       tick("r_start", 1, 1, 3'd0, $urandom, ir);
        1, 2:    tick("r_stop", 1, 1, 3'd1, $urandom, ir);
        3:       tick("r_status", 1, 0, 3'd2, 0, ir);
        4:       tick("r_cyc", 1, 0, 3'd3, 0, ir);
        5:       tick("r_id", 1, 0, 3'd4, 0, ir);
        6:       tick("r_ret", 1, 0, 3'd6, 0, ir);
        7:       tick("r_pop", 1, 1, 3'd5, 0, ir);
        8:       tick("r_stw", 1, 1, 3'd2, $urandom, ir);
        9:       tick("r_off7", 1, 1'($urandom), 3'd7, $urandom, ir);
        default: tick("r_idle", 0, 0, 3'd0, 0, ir);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_region_ctrl.md
PERF_REGION_CTRL -- requirements
Module: perf_region_ctrl

Interface
REQ-001 The module SHALL have parameter FifoDepth, default 8, giving the number of completed-region records buffered (power of two, 2..16).
REQ-002 The module SHALL have parameter CntWidth, default 32, giving the cycle-counter width (1..32).
REQ-003 Port clk_i: input, 1 bit, the single clock; all state is clocked on its rising edge.
REQ-004 Port rst_ni: input, 1 bit, asynchronous active-low reset.
REQ-005 Port req_i: input, 1 bit, device-bus request, valid for one cycle.
REQ-006 Port we_i: input, 1 bit, write enable qualifying req_i.
REQ-007 Port be_i: input, 4 bits, byte enables; ignored, all accesses are treated as full-word.
REQ-008 Port addr_i: input, 32 bits, byte address; only addr_i[4:2] is decoded.
REQ-009 Port wdata_i: input, 32 bits, write data.
REQ-010 Port instr_ret_i: input, 1 bit, core retired-instruction strobe.
REQ-011 Port rvalid_o: output, 1 bit, response valid, for reads and writes alike.
REQ-012 Port rdata_o: output, 32 bits, read data, valid with rvalid_o.

Function
REQ-013 Word offsets SHALL be: 0 START, 1 STOP, 2 STATUS, 3 HEAD_CYC, 4 HEAD_ID, 5 POP, 6 HEAD_RET; other offsets read 0 and ignore writes.
REQ-014 rvalid_o SHALL assert exactly one cycle after every accepted req_i; rdata_o SHALL be 0 on writes and whenever rvalid_o is low.
REQ-015 The FSM SHALL have states IDLE and RUN; reset enters IDLE.
REQ-016 Write START in IDLE: latch wdata_i[7:0] as region id, clear counters, go to RUN.
REQ-017 Write START in RUN: restart (discard current region, latch new id, clear counters), stay RUN, no record pushed.
REQ-018 In RUN the cycle counter SHALL increment once per cycle, starting the cycle after START, saturating at all-ones (no wrap).
REQ-019 Write STOP in RUN: push {id, cycles, retired} with cycles counted inclusive of the STOP cycle (START at t, STOP at t+N gives N), go to IDLE.
REQ-020 Write STOP in IDLE: no effect.
REQ-021 STOP with FIFO full: record dropped, sticky overflow flag set, FSM still returns to IDLE.
REQ-022 STATUS read: bit0 = RUN, bit1 = overflow, bits[8:4] = FIFO occupancy, others 0; any STATUS write clears overflow.
REQ-023 HEAD_CYC/HEAD_ID/HEAD_RET SHALL return the oldest record's fields zero-extended, or 0 when empty; reads never pop.
REQ-024 Write POP: remove head if non-empty; on empty, no effect.
REQ-025 POP and STOP in the same cycle are impossible (single bus); pop of a full FIFO frees a slot for any later STOP.
REQ-026 FIFO pointers SHALL wrap modulo FifoDepth; occupancy 0..FifoDepth exact.

Reset
REQ-027 Reset SHALL clear FSM to IDLE, counters, id, FIFO pointers/occupancy, overflow, rvalid_o=0, rdata_o=0, asynchronously, including mid-region (the region is lost, no record).

Configuration
REQ-028 With macro PERF_REGION_INSTRET_EN defined, a retired-instruction counter (CntWidth, saturating, same start/stop window as cycles) SHALL count instr_ret_i pulses and be stored per record.
REQ-029 Without PERF_REGION_INSTRET_EN, instr_ret_i SHALL be ignored, no counter or FIFO storage for it exists, and HEAD_RET reads 0.

Structure
REQ-030 Package perf_region_pkg SHALL hold register offset constants, the state enum, and the record struct typedef.
REQ-031 Record storage SHALL be a sub-module perf_region_fifo (synchronous push/pop, full/empty/count outputs, parameterised width/depth).

Verification
REQ-032 START id 0x5A at t, STOP at t+100, read HEAD_CYC -> 100, HEAD_ID -> 0x5A, STATUS bit0=0, occupancy=1.
REQ-033 Nine START/STOP pairs with FifoDepth=8 -> occupancy 8, overflow=1; STATUS write -> overflow=0; eight POPs -> occupancy 0, HEAD_CYC reads 0.
REQ-034 START 0x01, 50 cycles, START 0x02, STOP 20 cycles later -> single record id 0x02, cycles 20.
REQ-035 CntWidth=8, region 300 cycles -> HEAD_CYC = 0xFF; STOP in IDLE -> occupancy unchanged.
REQ-036 rst_ni low for 2 cycles mid-RUN -> STATUS reads 0, occupancy 0, rvalid_o low during reset.
REQ-037 With PERF_REGION_INSTRET_EN, 37 instr_ret_i pulses inside region -> HEAD_RET = 37; without macro -> HEAD_RET = 0.
